// File: rtl/rf_wb_arbiter_if.sv
// Write-back request/grant bundle between the execution units and the register-bank arbiter.
// Forwarding ports exist only when RF_WB_FWD_EN is defined.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32
);
   logic                  hold;
   logic [2:0]            req_valid;
   logic [14:0]           req_rd;
   logic [3*DATA_W-1:0]   req_data;
   logic [2:0]            req_ready;
   logic                  wEnable;
   logic [4:0]            rd;
   logic [DATA_W-1:0]     rdIn;
   logic                  busy;
`ifdef RF_WB_FWD_EN
   logic [4:0]            rs;
   logic [4:0]            rt;
   logic                  fwd_rs_hit;
   logic                  fwd_rt_hit;
   logic [DATA_W-1:0]     fwd_rs_data;
   logic [DATA_W-1:0]     fwd_rt_data;

   modport master (
      output hold, req_valid, req_rd, req_data, rs, rt,
      input  req_ready, wEnable, rd, rdIn, busy,
             fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data
   );

   modport slave (
      input  hold, req_valid, req_rd, req_data, rs, rt,
      output req_ready, wEnable, rd, rdIn, busy,
             fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data
   );
`else
   modport master (
      output hold, req_valid, req_rd, req_data,
      input  req_ready, wEnable, rd, rdIn, busy
   );

   modport slave (
      input  hold, req_valid, req_rd, req_data,
      output req_ready, wEnable, rd, rdIn, busy
   );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: grants one of ALU/load/muldiv per cycle and issues the
// register-bank write one cycle later. Define RF_WB_FWD_EN to add write-cycle forwarding.
module rf_wb_arbiter #(
   parameter int DATA_W      = 32,
   parameter int INIT_CYCLES = 2
) (
   input logic         clk,
   input logic         rst,
   rf_wb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;

   localparam int CNT_W = $clog2(INIT_CYCLES + 1);

   state_t              state;
   state_t              state_next;
   logic [CNT_W-1:0]    init_cnt;
   logic [1:0]          ptr;
   logic [1:0]          cand [3];
   logic [1:0]          grant_idx;
   logic                xfer;
   logic [2:0]          grant;
   logic [4:0]          sel_rd;
   logic [DATA_W-1:0]   sel_data;
   logic                wr_en_q;
   logic [4:0]          wr_rd_q;
   logic [DATA_W-1:0]   wr_data_q;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == INIT)
            init_cnt <= init_cnt + 1'b1;
      end
   end

   // INIT holds off grants until the counter has seen INIT_CYCLES edges.
   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (init_cnt == CNT_W'(INIT_CYCLES - 1))
                     state_next = bus.hold ? HOLD : RUN;
         RUN:     if (bus.hold)  state_next = HOLD;
         HOLD:    if (!bus.hold) state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   // Search starts at ptr and wraps, so a lone requester always wins regardless of ptr.
   always_comb begin
      cand[0]   = ptr;
      cand[1]   = inc3(ptr);
      cand[2]   = inc3(inc3(ptr));
      grant_idx = ptr;
      xfer      = 1'b0;
      if (state == RUN && !bus.hold) begin
         for (int k = 0; k < 3; k++) begin
            if (!xfer && bus.req_valid[cand[k]]) begin
               xfer      = 1'b1;
               grant_idx = cand[k];
            end
         end
      end
      grant = xfer ? (3'b001 << grant_idx) : 3'b000;
   end

   always_comb begin
      sel_rd   = bus.req_rd[4:0];
      sel_data = bus.req_data[DATA_W-1:0];
      case (grant_idx)
         2'd1: begin
            sel_rd   = bus.req_rd[9:5];
            sel_data = bus.req_data[2*DATA_W-1:DATA_W];
         end
         2'd2: begin
            sel_rd   = bus.req_rd[14:10];
            sel_data = bus.req_data[3*DATA_W-1:2*DATA_W];
         end
         default: ;
      endcase
   end

   // Async reset drops any pending write; rd/rdIn keep the last value between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_rd_q   <= '0;
         wr_data_q <= '0;
         ptr       <= 2'd0;
      end else begin
         wr_en_q <= xfer;
         if (xfer) begin
            wr_rd_q   <= sel_rd;
            wr_data_q <= sel_data;
            ptr       <= inc3(grant_idx);
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.wEnable   = wr_en_q;
   assign bus.rd        = wr_rd_q;
   assign bus.rdIn      = wr_data_q;
   assign bus.busy      = (state != RUN) || wr_en_q;

`ifdef RF_WB_FWD_EN
   // The bank still returns the old value during its write cycle, so bypass it here.
   assign bus.fwd_rs_hit  = wr_en_q && (wr_rd_q == bus.rs);
   assign bus.fwd_rt_hit  = wr_en_q && (wr_rd_q == bus.rt);
   assign bus.fwd_rs_data = wr_data_q;
   assign bus.fwd_rt_data = wr_data_q;
`endif

endmodule
